// File: rtl/m_serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and default width.
package m_serial_addsub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/m_fulladder.sv
// One-bit full adder cell, reused as the datapath of the serial adder.
module m_fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/m_serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell consumes one operand bit per clock, LSB first.
module m_serial_addsub
  import m_serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;

  logic w_s;
  logic w_c;

  m_fulladder u_cell (
    .A    (r_opa[0]),
    .B    (r_opb[0]),
    .Cin  (r_carry),
    .S    (w_s),
    .Cout (w_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_sh     <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sh    <= {w_s, r_sh[WIDTH-1:1]};
          r_carry <= w_c;
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          if (r_cnt == LAST_BIT) begin
            // r_carry still holds the carry into the MSB cell on this edge.
            r_result <= {w_s, r_sh[WIDTH-1:1]};
            r_cout   <= w_c;
            r_ovf    <= r_carry ^ w_c;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_m_serial_addsub.sv
// Directed and exhaustive checks of m_serial_addsub against an arithmetic reference model.
module tb_m_serial_addsub;

  localparam int W = 4;
  localparam int M = 1 << W;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   last_acc = -1000;
  int   free_at  = 0;
  exp_t q[$];

  m_serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic, unsigned for carry/borrow and signed for overflow.
  function automatic exp_t model(input int av, input int bv, input bit sv);
    exp_t e;
    int   r;
    int   sa;
    int   sb;
    int   sr;
    r    = sv ? (av - bv) : (av + bv);
    e.r  = W'(((r % M) + M) % M);
    e.c  = sv ? (av >= bv) : (r >= M);
    sa   = (av >= M / 2) ? av - M : av;
    sb   = (bv >= M / 2) ? bv - M : bv;
    sr   = sv ? (sa - sb) : (sa + sb);
    e.o  = (sr < -(M / 2)) || (sr >= M / 2);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Model decides acceptance from the IDLE-only rule; inputs change 1 time unit after a rising edge.
  task automatic start_op(input int av, input int bv, input bit sv);
    a     = W'(av);
    b     = W'(bv);
    sub   = sv;
    start = 1'b1;
    if (cyc + 1 >= free_at) begin
      q.push_back(model(av, bv, sv));
      last_acc = cyc + 1;
      free_at  = cyc + 1 + W + 2;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_lit(input logic [W-1:0] er, input logic ec, input logic eo, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, "_result"}, 32'(result), 32'(er));
      chk({nm, "_cout"}, 32'(cout), 32'(ec));
      chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
    end
    @(posedge clk);
    #1;
  endtask

  // Cycle-by-cycle compare: busy window, single done pulse at the model's due cycle, result values.
  always @(negedge clk) begin
    if (rst_n) begin
      bit   exp_busy;
      bit   exp_done;
      exp_t e;
      exp_busy = (cyc >= last_acc) && (cyc <= last_acc + W);
      exp_done = (cyc == last_acc + W);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        if (q.size() == 0) begin
          chk("model_queue_nonempty", 32'd0, 32'd1);
        end else begin
          e = q.pop_front();
          if (done) begin
            chk("result", 32'(result), 32'(e.r));
            chk("cout", 32'(cout), 32'(e.c));
            chk("ovf", 32'(ovf), 32'(e.o));
            $display("op a=%0d b=%0d sub=%0b -> result=%0h cout=%0b ovf=%0b", dut.a, dut.b, dut.sub,
                     result, cout, ovf);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t m;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;

    // Model pinned to hand-computed values.
    m = model(5, 3, 0);
    chk("model_5p3", 32'({m.o, m.c, m.r}), 32'({1'b1, 1'b0, 4'd8}));
    m = model(3, 5, 1);
    chk("model_3m5", 32'({m.o, m.c, m.r}), 32'({1'b0, 1'b0, 4'hE}));
    m = model(9, 9, 1);
    chk("model_9m9", 32'({m.o, m.c, m.r}), 32'({1'b0, 1'b1, 4'h0}));

    // 1: reset values, then idle with start low.
    #3;
    chk("rst_outputs", 32'({busy, done, result, cout, ovf}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_wait(10);

    // 2/3: directed add and subtract.
    start_op(5, 3, 0);
    wait_lit(4'd8, 1'b0, 1'b1, "add_5_3");
    idle_wait(1);
    start_op(3, 5, 1);
    wait_lit(4'hE, 1'b0, 1'b0, "sub_3_5");
    idle_wait(1);
    start_op(9, 9, 1);
    wait_lit(4'h0, 1'b1, 1'b0, "sub_9_9");
    idle_wait(1);

    // 5: second start two cycles into an operation is ignored.
    start_op(6, 1, 0);
    idle_wait(1);
    start_op(2, 2, 1);
    wait_lit(4'd7, 1'b0, 1'b0, "busy_ignore");
    idle_wait(W + 2);

    // 6: reset during RUN aborts at once with no done.
    start_op(4, 3, 0);
    idle_wait(1);
    rst_n = 1'b0;
    q.delete();
    last_acc = -1000;
    free_at  = 0;
    #1;
    chk("midrst_outputs", 32'({busy, done, result, cout, ovf}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_op(7, 2, 1);
    wait_lit(4'd5, 1'b1, 1'b0, "after_rst_7m2");
    idle_wait(1);

    // 4: exhaustive at minimum period; the compare process checks every result.
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < M; x++) begin
        for (int y = 0; y < M; y++) begin
          start_op(x, y, s[0]);
          idle_wait(W + 1);
        end
      end
    end
    idle_wait(W + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
